// File: rtl/freq_divider_monitor.sv
// Measures period/high time of the divided clock and checks period against div_exp.
// Latency: results register on the closing rise edge; meas_valid follows for one cycle; no backpressure.
module freq_divider_monitor #(
    parameter int unsigned TOL      = 0,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  fsel,
    input  logic [31:0] div_exp,
    input  logic        fout,
    input  logic        clr,
    output logic [31:0] period_out,
    output logic [31:0] high_out,
    output logic        meas_valid,
    output logic        locked,
    output logic        err_sticky
);
    localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE
    } state_t;

    state_t         state;
    logic           fout_d;
    logic [2:0]     fsel_d;
    logic [31:0]    pcnt;
    logic [31:0]    hcnt;
    logic [MW-1:0]  mcnt;
    logic [SW-1:0]  scnt;

    logic               rise;
    logic               fsel_chg;
    logic               div_ok;
    logic               tmo;
    logic               match;
    logic               err_set;
    logic signed [32:0] diff;
    logic [32:0]        mag;
    logic [33:0]        limit;

    assign rise     = fout & ~fout_d;
    assign fsel_chg = (fsel != fsel_d);
    assign div_ok   = (div_exp >= 32'd2);

    assign diff  = $signed({1'b0, pcnt}) - $signed({1'b0, div_exp});
    assign mag   = diff[32] ? $unsigned(-diff) : $unsigned(diff);
    assign match = (mag <= 33'(TOL));

    // A select change outranks a timeout, so it is masked here as well as in the FSM.
    assign limit   = {1'b0, div_exp, 1'b0} + 34'(TOL);
    assign tmo     = div_ok & ~rise & ~fsel_chg & ({2'b00, pcnt} > limit);
    assign err_set = tmo | (div_ok & ~fsel_chg & rise & (state == ST_MEASURE) & ~match);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            fout_d     <= 1'b0;
            fsel_d     <= 3'd0;
            pcnt       <= 32'd0;
            hcnt       <= 32'd0;
            mcnt       <= '0;
            scnt       <= '0;
            period_out <= 32'd0;
            high_out   <= 32'd0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            fout_d     <= fout;
            fsel_d     <= fsel;
            meas_valid <= 1'b0;

            // Counters are held at zero while the divider output is static so that a
            // later switch to a real ratio does not start from a stale, huge count.
            if (!div_ok || tmo) begin
                pcnt <= 32'd0;
                hcnt <= 32'd0;
            end else if (rise) begin
                pcnt <= 32'd1;
                hcnt <= 32'd1;
            end else begin
                if (pcnt != '1) pcnt <= pcnt + 32'd1;
                if (fout && hcnt != '1) hcnt <= hcnt + 32'd1;
            end

            if (err_set)  err_sticky <= 1'b1;
            else if (clr) err_sticky <= 1'b0;

            if (fsel_chg || !div_ok || tmo) begin
                state  <= ST_IDLE;
                mcnt   <= '0;
                locked <= 1'b0;
            end else if (rise) begin
                case (state)
                    ST_IDLE: begin
                        scnt  <= '0;
                        state <= (SETTLE == 0) ? ST_MEASURE : ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (32'(scnt) + 32'd1 >= SETTLE) state <= ST_MEASURE;
                        else                             scnt  <= scnt + 1'b1;
                    end
                    ST_MEASURE: begin
                        period_out <= pcnt;
                        high_out   <= hcnt;
                        meas_valid <= 1'b1;
                        if (match) begin
                            if (mcnt < LOCK_MAX) mcnt <= mcnt + 1'b1;
                            if (32'(mcnt) + 32'd1 >= LOCK_CNT) locked <= 1'b1;
                        end else begin
                            mcnt   <= '0;
                            locked <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_freq_divider_monitor.sv
// Directed bench for freq_divider_monitor with default parameters (TOL=0, SETTLE=2, LOCK_CNT=4).
module tb_freq_divider_monitor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  fsel;
    logic [31:0] div_exp;
    logic        fout;
    logic        clr;
    logic [31:0] period_out;
    logic [31:0] high_out;
    logic        meas_valid;
    logic        locked;
    logic        err_sticky;

    int errors = 0;
    int checks = 0;
    int mv_cnt = 0;
    logic [31:0] r_p, r_h;
    logic        r_mv, r_lk, r_err;

    freq_divider_monitor dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fsel       (fsel),
        .div_exp    (div_exp),
        .fout       (fout),
        .clr        (clr),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk cycle with the given fout/clr; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic f, input logic c);
        fout = f;
        clr  = c;
        @(posedge clk);
        #1;
        if (meas_valid) mv_cnt++;
    endtask

    // One divided-clock period: d cycles, h high; snapshot outputs just after its opening rise.
    task automatic wave(input int d, input int h, input logic c);
        for (int i = 0; i < d; i++) begin
            cyc(i < h, (i == 0) ? c : 1'b0);
            if (i == 0) begin
                r_mv  = meas_valid;
                r_p   = period_out;
                r_h   = high_out;
                r_lk  = locked;
                r_err = err_sticky;
            end
        end
    endtask

    initial begin
        reset_n = 1'b1; fsel = 3'd0; div_exp = 32'd8; fout = 1'b0; clr = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", period_out, 0);
        chk("rst_high", high_out, 0);
        chk("rst_mv", meas_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_sticky, 0);

        // Clean lock
        reset_n = 1'b1;
        mv_cnt = 0;
        repeat (3) wave(8, 4, 1'b0);
        chk("settle_no_mv", mv_cnt, 0);
        wave(8, 4, 1'b0);
        chk("r4_mv", r_mv, 1);
        chk("r4_period", r_p, 8);
        chk("r4_high", r_h, 4);
        chk("r4_locked", r_lk, 0);
        repeat (2) wave(8, 4, 1'b0);
        chk("r6_locked", r_lk, 0);
        wave(8, 4, 1'b0);
        chk("r7_locked", r_lk, 1);
        chk("r7_err", r_err, 0);
        chk("lock_mv_count", mv_cnt, 4);

        // Single long period
        wave(9, 4, 1'b0);
        chk("r8_locked", r_lk, 1);
        wave(8, 4, 1'b0);
        chk("mis_mv", r_mv, 1);
        chk("mis_period", r_p, 9);
        chk("mis_locked", r_lk, 0);
        chk("mis_err", r_err, 1);
        repeat (3) wave(8, 4, 1'b0);
        chk("relock_r12", r_lk, 0);
        wave(8, 4, 1'b0);
        chk("relock_r13", r_lk, 1);
        chk("err_held", r_err, 1);
        wave(8, 4, 1'b1);
        chk("clr_err", r_err, 0);

        // clr coinciding with a mismatch
        wave(9, 4, 1'b0);
        wave(8, 4, 1'b1);
        chk("clr_mis_period", r_p, 9);
        chk("clr_mis_err", r_err, 1);
        wave(8, 4, 1'b1);
        chk("clr_after", r_err, 0);
        repeat (3) wave(8, 4, 1'b0);
        chk("pre_tmo_locked", r_lk, 1);

        // Timeout: fout stuck low; cycles 8..16 after the rise are still in tolerance
        repeat (9) cyc(1'b0, 1'b0);
        chk("tmo_c16_err", err_sticky, 0);
        chk("tmo_c16_locked", locked, 1);
        cyc(1'b0, 1'b0);
        chk("tmo_c17_err", err_sticky, 1);
        chk("tmo_c17_locked", locked, 0);
        cyc(1'b0, 1'b1);
        chk("tmo_clr", err_sticky, 0);
        mv_cnt = 0;
        repeat (3) wave(8, 4, 1'b0);
        chk("tmo_idle_no_mv", mv_cnt, 0);
        wave(8, 4, 1'b0);
        chk("tmo_rest_mv", r_mv, 1);
        chk("tmo_rest_period", r_p, 8);
        repeat (3) wave(8, 4, 1'b0);
        chk("tmo_relock", r_lk, 1);

        // fsel change mid-period while locked
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        fsel = 3'd1;
        div_exp = 32'd16;
        cyc(1'b1, 1'b0);
        chk("fsel_unlock", locked, 0);
        chk("fsel_hold_period", period_out, 8);
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);
        mv_cnt = 0;
        repeat (3) wave(16, 8, 1'b0);
        chk("fsel_settle_no_mv", mv_cnt, 0);
        wave(16, 8, 1'b0);
        chk("fsel_mv", r_mv, 1);
        chk("fsel_period", r_p, 16);
        chk("fsel_high", r_h, 8);
        chk("fsel_err", r_err, 0);

        // div_exp = 1: static output, nothing reported
        div_exp = 32'd1;
        mv_cnt = 0;
        repeat (20) cyc(1'b1, 1'b0);
        chk("div1_no_mv", mv_cnt, 0);
        chk("div1_err", err_sticky, 0);
        chk("div1_locked", locked, 0);

        // div_exp = 2: fastest toggling
        div_exp = 32'd2;
        cyc(1'b0, 1'b0);
        mv_cnt = 0;
        repeat (3) wave(2, 1, 1'b0);
        chk("div2_settle", mv_cnt, 0);
        wave(2, 1, 1'b0);
        chk("div2_mv", r_mv, 1);
        chk("div2_period", r_p, 2);
        chk("div2_high", r_h, 1);
        repeat (3) wave(2, 1, 1'b0);
        chk("div2_locked", r_lk, 1);
        chk("div2_pulses", mv_cnt, 4);
        chk("div2_err", err_sticky, 0);
        wave(3, 1, 1'b0);
        wave(2, 1, 1'b0);
        chk("div2_mis_period", r_p, 3);
        chk("div2_mis_err", r_err, 1);
        cyc(1'b1, 1'b0);
        chk("pre_rst_mv", meas_valid, 1);

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        chk("arst_period", period_out, 0);
        chk("arst_high", high_out, 0);
        chk("arst_mv", meas_valid, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err_sticky, 0);
        repeat (2) @(posedge clk);
        #1;
        // fsel is still 1 at release: the first rise coincides with a select change and is dropped
        reset_n = 1'b1;
        div_exp = 32'd8;
        mv_cnt = 0;
        repeat (4) wave(8, 4, 1'b0);
        chk("post_rst_no_mv", mv_cnt, 0);
        wave(8, 4, 1'b0);
        chk("post_rst_mv", r_mv, 1);
        chk("post_rst_period", r_p, 8);
        chk("post_rst_high", r_h, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/freq_divider_monitor.md
# freq_divider_monitor

Checks the output of the programmable frequency divider. It sits directly downstream of the divider on the same clock. For each period of the divided output it measures the period and the high time, then compares the period against the divisor the divider was programmed with. It reports per-period measurements, a `locked` status, and a sticky error, so control logic can confirm the divider is running at the selected ratio before using its output.

## Interface
Parameters:
- `TOL`, default 0: allowed absolute difference between measured period and `div_exp`, in clk cycles.
- `SETTLE`, default 2: number of complete periods discarded after reset or after a `fsel` change.
- `LOCK_CNT`, default 4: number of consecutive matching periods required to assert `locked`.

Ports:
- `clk`, input, 1: the divider's input clock. One clock domain; `fout` is already synchronous to it.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `fsel`, input, 3: divider select. Watched only for changes.
- `div_exp`, input, 32: expected period in clk cycles. This is the decoded divisor for the current `fsel`.
- `fout`, input, 1: registered divider output.
- `clr`, input, 1: synchronous clear of `err_sticky`.
- `period_out`, output, 32: last measured period, in clk cycles.
- `high_out`, output, 32: number of clk cycles `fout` was high in that period.
- `meas_valid`, output, 1: one-cycle pulse marking new `period_out`/`high_out`.
- `locked`, output, 1: `LOCK_CNT` consecutive periods have matched.
- `err_sticky`, output, 1: a mismatch or timeout has occurred since the last clear.

## Operation
- **Edge detection:** `fout_d` is `fout` registered. `rise = fout & ~fout_d`.
- **Counters:**
  - `pcnt` (32-bit, saturating) counts clk cycles since the last rise.
  - `hcnt` (32-bit) counts cycles with `fout` = 1.
  - Both restart on every rise.
  - For a clean waveform of period D, the captured period equals D exactly.
- **State machine:**
  - IDLE: waiting for the first rise. On a rise, go to SETTLE with the settle count set to 0.
  - SETTLE: each rise completes one discarded period. After `SETTLE` of them, go to MEASURE. If `SETTLE` = 0, go straight from IDLE to MEASURE.
  - MEASURE: each rise closes a period. Load `period_out`/`high_out` and pulse `meas_valid`.
- **Match test:** a period matches when |period − `div_exp`| ≤ `TOL`. Use 33-bit signed difference arithmetic.
  - On a match, increment the match counter, saturating at `LOCK_CNT`. `locked` = 1 once the counter reaches `LOCK_CNT`.
  - On a mismatch, clear the match counter, clear `locked`, set `err_sticky`, and stay in MEASURE.
- **Timeout:** applies in every state, and only when `div_exp` ≥ 2. If `pcnt` exceeds 2·`div_exp` + `TOL` (34-bit compare) with no rise:
  - set `err_sticky`;
  - clear `locked` and the match counter;
  - go to IDLE and restart `pcnt`.
- **`fsel` change:** `fsel_d` is `fsel` registered. Whenever `fsel` ≠ `fsel_d`, in any state:
  - go to IDLE;
  - clear `locked` and the match counter;
  - suppress `meas_valid`.
  - This has priority over a coincident rise or timeout.
  - `period_out`/`high_out` hold their values.
- **`div_exp` < 2:** the divider output is constant, so no edges are expected. Hold IDLE, `locked` = 0, no timeout, no error.
- **`clr`:** clears `err_sticky`. If a new error occurs in the same cycle, the error wins and `err_sticky` stays 1.

## Timing
- **Reset values:**
  - `period_out` = 0, `high_out` = 0.
  - `meas_valid` = 0, `locked` = 0, `err_sticky` = 0.
  - State = IDLE, all counters 0, `fout_d` = 0, `fsel_d` = 0.
- **Reset side effects (no error flagged in either case):**
  - If `fout` = 1 in the first cycle after reset, that counts as the opening rise.
  - If `fsel` ≠ 0 in the first cycle after reset, that counts as a change and returns the block to IDLE.
- **Measurement latency:** the rise is detected in the cycle where `fout` = 1 and `fout_d` = 0. At that clk edge, `period_out`, `high_out`, `locked` and `err_sticky` update, and `meas_valid` is high for exactly the following cycle.
- **Reset mid-measurement:** immediate asynchronous return to the reset values. No partial result is emitted.
- **Back-to-back periods:** the minimum D is 2, so `meas_valid` pulses at most every 2 cycles. Consecutive pulses are never merged.

## Test plan
- **Clean lock:** `div_exp` = 8, `fout` period 8 with high 4, TOL = 0, SETTLE = 2, LOCK_CNT = 4.
  - Rises 1–3 produce no `meas_valid`.
  - Rises 4–7 each pulse `meas_valid` with `period_out` = 8 and `high_out` = 4.
  - `locked` rises at rise 7; `err_sticky` stays 0.
- **Mismatch:** after lock, one period of 9.
  - `meas_valid` with `period_out` = 9; `locked` falls and `err_sticky` = 1.
  - Four further periods of 8 re-assert `locked`; `err_sticky` stays 1 until `clr`.
- **Timeout:** `div_exp` = 8 and `fout` stuck low after lock.
  - 17 cycles after the last rise, `err_sticky` = 1, `locked` = 0, state = IDLE.
- **`fsel` change:** change `fsel` mid-period while locked with `div_exp` 8 → 16.
  - Next cycle `locked` = 0.
  - Two periods of 16 are discarded; the first `meas_valid` reports 16.
- **Boundary:**
  - `div_exp` = 1 with `fout` held at 1: no `meas_valid`, no error.
  - `div_exp` = 2, alternating `fout`: `period_out` = 2 and `high_out` = 1.
  - `clr` and a mismatch in the same cycle: `err_sticky` stays 1.
- **Async reset mid-MEASURE:** assert `reset_n` = 0 between clk edges. All outputs go to 0 immediately, and after release the block restarts from IDLE.
